// File: rtl/bus_seq_pkg.sv
// Shared definitions for the register-bus sequencer: command opcodes, FSM states
// and the default register map.
package bus_seq_pkg;

    typedef enum logic [1:0] {
        OP_XFER  = 2'd0,
        OP_FETCH = 2'd1,
        OP_INC   = 2'd2,
        OP_CLR   = 2'd3
    } op_e;

    typedef enum logic [3:0] {
        StIdle,
        StDrive,
        StLoad,
        StFDrv1,
        StFLd1,
        StFDrv2,
        StFLd2,
        StStrobe,
        StDone
    } state_e;

    localparam int unsigned DEF_N_REGS  = 8;
    localparam int unsigned DEF_SEL_W   = 3;
    localparam int unsigned DEF_PC_IDX  = 2;
    localparam int unsigned DEF_AR_IDX  = 1;
    localparam int unsigned DEF_MEM_IDX = 7;
    localparam int unsigned DEF_IR_IDX  = 4;

endpackage

// File: rtl/bus_onehot_dec.sv
// Index-to-one-hot decoder with enable; an index beyond the vector width decodes to zero.
module bus_onehot_dec #(
    parameter int unsigned N_REGS = 8,
    parameter int unsigned SEL_W  = 3
) (
    input  logic [SEL_W-1:0]  idx,
    input  logic              en,
    output logic [N_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < N_REGS; i++) begin
            if (en && (32'(idx) == i)) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_sequencer.sv
// Register-bus initiator: turns XFER/FETCH/INC/CLR commands into registered
// drive/load/inc/clear strobes, with drive always leading load by one cycle.
module bus_sequencer
    import bus_seq_pkg::*;
#(
    parameter int unsigned N_REGS  = DEF_N_REGS,
    parameter int unsigned SEL_W   = DEF_SEL_W,
    parameter int unsigned PC_IDX  = DEF_PC_IDX,
    parameter int unsigned AR_IDX  = DEF_AR_IDX,
    parameter int unsigned MEM_IDX = DEF_MEM_IDX,
    parameter int unsigned IR_IDX  = DEF_IR_IDX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [SEL_W-1:0]  cmd_src,
    input  logic [SEL_W-1:0]  cmd_dst,
    output logic [N_REGS-1:0] read_en,
    output logic [N_REGS-1:0] load_en,
    output logic [N_REGS-1:0] inc_en,
    output logic [N_REGS-1:0] clr_en,
    output logic              done,
    output logic              err
);

    localparam logic [SEL_W-1:0] PC_SEL  = SEL_W'(PC_IDX);
    localparam logic [SEL_W-1:0] AR_SEL  = SEL_W'(AR_IDX);
    localparam logic [SEL_W-1:0] MEM_SEL = SEL_W'(MEM_IDX);
    localparam logic [SEL_W-1:0] IR_SEL  = SEL_W'(IR_IDX);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [SEL_W-1:0] src_q, src_d, dst_q, dst_d;
    logic             bad_q, bad_d;
    logic             src_oob, dst_oob;

    assign cmd_ready = (state_q == StIdle);
    assign src_oob   = (32'(cmd_src) >= N_REGS);
    assign dst_oob   = (32'(cmd_dst) >= N_REGS);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        bad_d   = bad_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    op_d  = op_e'(cmd_op);
                    src_d = cmd_src;
                    dst_d = cmd_dst;
                    case (op_e'(cmd_op))
                        OP_XFER:  bad_d = (cmd_src == cmd_dst) | src_oob | dst_oob;
                        OP_FETCH: bad_d = 1'b0;
                        default:  bad_d = dst_oob;
                    endcase
                    // Rejected commands skip straight to DONE so no strobe ever fires.
                    if (bad_d) begin
                        state_d = StDone;
                    end else begin
                        case (op_e'(cmd_op))
                            OP_XFER:  state_d = StDrive;
                            OP_FETCH: state_d = StFDrv1;
                            default:  state_d = StStrobe;
                        endcase
                    end
                end
            end
            StDrive:  state_d = StLoad;
            StLoad:   state_d = StDone;
            StFDrv1:  state_d = StFLd1;
            StFLd1:   state_d = StFDrv2;
            StFDrv2:  state_d = StFLd2;
            StFLd2:   state_d = StDone;
            StStrobe: state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Strobes are decoded from the next state so they can be registered alongside it.
    logic             rd_go, ld_go, inc_go, clr_go;
    logic [SEL_W-1:0] rd_idx, ld_idx, inc_idx;

    always_comb begin
        rd_go   = 1'b0;
        ld_go   = 1'b0;
        inc_go  = 1'b0;
        clr_go  = 1'b0;
        rd_idx  = src_d;
        ld_idx  = dst_d;
        inc_idx = dst_d;
        case (state_d)
            StDrive: rd_go = 1'b1;
            StLoad: begin
                rd_go = 1'b1;
                ld_go = 1'b1;
            end
            StFDrv1: begin
                rd_go  = 1'b1;
                rd_idx = PC_SEL;
            end
            StFLd1: begin
                rd_go  = 1'b1;
                rd_idx = PC_SEL;
                ld_go  = 1'b1;
                ld_idx = AR_SEL;
            end
            StFDrv2: begin
                rd_go  = 1'b1;
                rd_idx = MEM_SEL;
            end
            StFLd2: begin
                rd_go   = 1'b1;
                rd_idx  = MEM_SEL;
                ld_go   = 1'b1;
                ld_idx  = IR_SEL;
                inc_go  = 1'b1;
                inc_idx = PC_SEL;
            end
            StStrobe: begin
                inc_go = (op_d == OP_INC);
                clr_go = (op_d == OP_CLR);
            end
            default: ;
        endcase
    end

    logic [N_REGS-1:0] rd_vec, ld_vec, inc_vec, clr_vec;

    bus_onehot_dec #(.N_REGS(N_REGS), .SEL_W(SEL_W)) u_dec_read (
        .idx(rd_idx), .en(rd_go), .onehot(rd_vec)
    );
    bus_onehot_dec #(.N_REGS(N_REGS), .SEL_W(SEL_W)) u_dec_load (
        .idx(ld_idx), .en(ld_go), .onehot(ld_vec)
    );
    bus_onehot_dec #(.N_REGS(N_REGS), .SEL_W(SEL_W)) u_dec_inc (
        .idx(inc_idx), .en(inc_go), .onehot(inc_vec)
    );
    bus_onehot_dec #(.N_REGS(N_REGS), .SEL_W(SEL_W)) u_dec_clr (
        .idx(dst_d), .en(clr_go), .onehot(clr_vec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= OP_XFER;
            src_q   <= '0;
            dst_q   <= '0;
            bad_q   <= 1'b0;
            read_en <= '0;
            load_en <= '0;
            inc_en  <= '0;
            clr_en  <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            bad_q   <= bad_d;
            read_en <= rd_vec;
            load_en <= ld_vec;
            inc_en  <= inc_vec;
            clr_en  <= clr_vec;
            done    <= (state_d == StDone);
            err     <= (state_d == StDone) & bad_d;
        end
    end

endmodule
